// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer driving an mpadder in two passes.
// Pass 1 forms a+b or a-b, pass 2 applies the -M / +M correction.
module mod_addsub_ctrl #(
  parameter int N  = 1024,
  parameter int AW = 1027
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [N-1:0]  in_m,
  output logic [N-1:0]  result,
  output logic          done,
  output logic          busy,
  output logic          add_start,
  output logic          add_subtract,
  output logic [AW-1:0] add_in_a,
  output logic [AW-1:0] add_in_b,
  input  logic [AW:0]   add_result,
  input  logic          add_done
);

  typedef enum logic [2:0] {
    IDLE,
    P1_ISSUE,
    P1_WAIT,
    P2_ISSUE,
    P2_WAIT,
    FINISH
  } state_t;

  localparam int XW = AW - N;

  state_t         state;
  state_t         state_nxt;
  logic           mode_q;
  logic [N-1:0]   m_q;
  logic [N-1:0]   s1_lo;
  logic           s1_neg;
  logic [N-1:0]   pick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = P1_ISSUE;
      P1_ISSUE: state_nxt = P1_WAIT;
      P1_WAIT:  if (add_done) state_nxt = P2_ISSUE;
      P2_ISSUE: state_nxt = P2_WAIT;
      P2_WAIT:  if (add_done) state_nxt = FINISH;
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    add_start = (state == P1_ISSUE) || (state == P2_ISSUE);
    done      = (state == FINISH);
    busy      = (state != IDLE) && (state != FINISH);
  end

  // Add mode keeps s2 unless s1 < M; subtract mode keeps s1 unless a < b.
  always_comb begin
    pick = '0;
    if (mode_q) begin
      pick = s1_neg ? add_result[N-1:0] : s1_lo;
    end else begin
      pick = add_result[AW] ? s1_lo : add_result[N-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= 1'b0;
      m_q          <= '0;
      s1_lo        <= '0;
      s1_neg       <= 1'b0;
      result       <= '0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q       <= mode;
            m_q          <= in_m;
            add_in_a     <= {{XW{1'b0}}, in_a};
            add_in_b     <= {{XW{1'b0}}, in_b};
            add_subtract <= mode;
          end
        end
        P1_WAIT: begin
          if (add_done) begin
            s1_lo        <= add_result[N-1:0];
            s1_neg       <= add_result[AW];
            add_in_a     <= add_result[AW-1:0];
            add_in_b     <= {{XW{1'b0}}, m_q};
            add_subtract <= ~mode_q;
          end
        end
        P2_WAIT: begin
          if (add_done) begin
            result <= pick;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
